// File: rtl/if_fetch_queue_pkg.sv
// Shared constants for the instruction-fetch front end.
package if_fetch_queue_pkg;

  // Bytes per instruction; the fetch PC advances by this amount per request.
  localparam int unsigned INSN_BYTES = 4;

  // Canonical no-op (addi x0, x0, 0), presented on out_instr while the queue is empty.
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_queue_queue.sv
// Circular buffer for {pc, instr} entries with a synchronous clear that
// overrides push and pop in the same cycle.
module if_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupled instruction-fetch front end: PC generation, imem request/response
// handshake, prefetch queue to decode, branch/jump redirect with kill of
// in-flight responses.
// Optional build macro IF_PERF_CNT_EN adds fetch/flush/stall counters.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_offset,
  input  logic            jmp_taken,
  input  logic [XLEN-1:0] jmp_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int unsigned     CW         = $clog2(DEPTH) + 1;
  localparam int unsigned     INSN_SHIFT = $clog2(INSN_BYTES);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSN_BYTES);
  localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(DEPTH);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     kill_q, kill_d;
  logic [XLEN-1:0]   target;
  logic              redirect;
  logic              req_fire;
  logic              kill_active;
  logic              push;
  logic              pop;
  logic [CW:0]       credit_used;
  logic [CW-1:0]     q_count;
  logic              q_empty;
  logic [2*XLEN-1:0] q_rdata;

  // Redirect select: jump wins over branch.
  always_comb begin
    redirect = jmp_taken | br_taken;
    target   = jmp_taken ? jmp_addr : br_pc + (br_offset << INSN_SHIFT);
  end

  // Issue credit, response acceptance and dequeue handshake.
  always_comb begin
    credit_used    = {1'b0, q_count} + {1'b0, inflight_q};
    imem_req_valid = !rst && !redirect && (credit_used < CREDIT_MAX);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    kill_active    = (kill_q != '0);
    push           = imem_resp_valid && !rst && !redirect && !kill_active;
    out_valid      = !rst && !redirect && !q_empty;
    pop            = out_valid && out_ready;
    out_pc         = q_rdata[2*XLEN-1:XLEN];
    out_instr      = q_empty ? XLEN'(NOP) : q_rdata[XLEN-1:0];
  end

  // Next-state for PCs and outstanding/kill counters. Responses arrive in
  // request order, so the PC of an accepted response is one step past the
  // previous accepted one, restarting at the redirect target.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    kill_d     = kill_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
    if (redirect) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      kill_d     = kill_q + inflight_q - CW'(imem_resp_valid);
    end else begin
      if (req_fire)                        fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push)                            resp_pc_d  = resp_pc_q + PC_STEP;
      if (imem_resp_valid && kill_active)  kill_d     = kill_q - CW'(1);
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      kill_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  if_queue #(
    .W     (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redirect),
    .push_i  (push),
    .wdata_i ({resp_pc_q, imem_resp_data}),
    .pop_i   (pop),
    .rdata_o (q_rdata),
    .count_o (q_count),
    .empty_o (q_empty)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_flush_q, perf_stall_q;

  // Event counters; free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pop)                     perf_fetch_q <= perf_fetch_q + 32'd1;
      if (redirect)                perf_flush_q <= perf_flush_q + 32'd1;
      if (out_valid && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: stimulus pushes expected {pc, instr}
// entries, a monitor pops them on every decode handshake, and the imem model
// checks the request address stream.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        br_taken, jmp_taken;
  logic [31:0] br_pc, br_offset, jmp_addr;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt;
`endif

  if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .br_taken        (br_taken),
    .br_pc           (br_pc),
    .br_offset       (br_offset),
    .jmp_taken       (jmp_taken),
    .jmp_addr        (jmp_addr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  entry_t      exp_q[$];
  pend_t       pend[$];
  int          errors = 0;
  int          checks = 0;
  int          pop_cnt = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] exp_base = 32'h0;
  int          exp_gen = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{pc + 32'(4*i), mem_word(pc + 32'(4*i))});
  endtask

  task automatic set_exp_addr(input logic [31:0] a);
    exp_base = a;
    exp_gen++;
  endtask

  // imem model: in-order responses lat cycles after acceptance; checks request addresses.
  initial begin : imem_model
    int last_gen = 0;
    int n = 0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
      @(negedge clk);
      if (rst) begin
        pend.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        if (exp_gen != last_gen) begin
          last_gen = exp_gen;
          n = 0;
        end
        chk("req_addr", imem_req_addr, exp_base + 32'(4*n));
        n++;
        pend.push_back('{imem_req_addr, cyc + lat});
      end
    end
  end

  // Monitor: every decode handshake must match the head of the expected queue.
  initial begin : monitor
    entry_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pop_pc", out_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    set_exp_addr(32'h0);
    @(negedge clk);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic redirect(input logic j, input logic b, input logic [31:0] ja,
                          input logic [31:0] bp, input logic [31:0] bo,
                          input logic [31:0] tgt, input string name);
    jmp_taken = j;
    br_taken  = b;
    jmp_addr  = ja;
    br_pc     = bp;
    br_offset = bo;
    set_exp_addr(tgt);
    @(negedge clk);
    chk({name, "_req_masked"}, {31'h0, imem_req_valid}, 32'h0);
    chk({name, "_out_masked"}, {31'h0, out_valid}, 32'h0);
    @(posedge clk); #2;
    jmp_taken = 1'b0;
    br_taken  = 1'b0;
  endtask

  task automatic check_next_req(input string name, input logic [31:0] a);
    @(negedge clk);
    chk({name, "_valid"}, {31'h0, imem_req_valid}, 32'h1);
    chk({name, "_addr"}, imem_req_addr, a);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int p0;
    int n;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    out_ready = 1'b0;
    br_taken = 1'b0;
    jmp_taken = 1'b0;
    br_pc = 32'h0;
    br_offset = 32'h0;
    jmp_addr = 32'h0;
    @(posedge clk); #2;

    // Sequential stream from reset, 1-cycle imem, decode always ready.
    do_reset();
    check_next_req("first_req", 32'h0);
    exp_push(32'h0, 12);
    @(posedge clk); #2;
    out_ready = 1'b1;
    n = 0;
    while (pop_cnt == 0 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    p0 = pop_cnt;
    repeat (8) begin
      @(posedge clk); #2;
    end
    chk("throughput_8cyc", pop_cnt - p0, 8);
    wait_drain("drain_stream");
    out_ready = 1'b0;

    // Decode stall: queue fills, issue stops, head holds.
    @(negedge clk);
    chk("stall_head_start", out_pc, 32'h30);
    repeat (10) begin
      @(posedge clk); #2;
    end
    @(negedge clk);
    chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
    chk("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("stall_head_end", out_pc, 32'h30);
    chk("stall_head_instr", out_instr, mem_word(32'h30));
    exp_push(32'h30, 8);
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain("drain_after_stall");
    out_ready = 1'b0;

    // Jump and branch together: jump wins.
    repeat (6) begin
      @(posedge clk); #2;
    end
    lat = 3;
    redirect(1'b1, 1'b1, 32'h100, 32'h40, 32'h1, 32'h100, "jmp_br");
    check_next_req("jmp_req", 32'h100);

    // Branch with two requests outstanding: both responses dropped.
    @(posedge clk); #2;
    @(posedge clk); #2;
    redirect(1'b0, 1'b1, 32'h0, 32'h20, 32'hFFFF_FFFE, 32'h18, "br");
    check_next_req("br_req", 32'h18);
    lat = 1;
    exp_push(32'h18, 6);
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain("drain_after_branch");
    out_ready = 1'b0;

    // Redirect coincident with a response while credits are exhausted.
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!(imem_resp_valid && !imem_req_valid) && n < 20);
    chk("found_full_resp", {31'h0, imem_resp_valid && !imem_req_valid}, 32'h1);
    redirect(1'b0, 1'b1, 32'h0, 32'h200, 32'h4, 32'h210, "br_full");
    @(negedge clk);
    chk("flush_empty", {31'h0, out_valid}, 32'h0);
    exp_push(32'h210, 5);
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain("drain_after_full_redirect");
    out_ready = 1'b0;

    // Reset in the middle of operation.
    repeat (3) begin
      @(posedge clk); #2;
    end
    do_reset();
    check_next_req("midrst_req", 32'h0);
    exp_push(32'h0, 4);
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain("drain_after_midrst");
    out_ready = 1'b0;

`ifdef IF_PERF_CNT_EN
    // 3 stall cycles, 5 pops, 2 back-to-back redirects.
    @(posedge clk); #2;
    do_reset();
    @(negedge clk);
    chk("perf_fetch_rst", perf_fetch_cnt, 32'd0);
    chk("perf_flush_rst", perf_flush_cnt, 32'd0);
    chk("perf_stall_rst", perf_stall_cnt, 32'd0);
    exp_push(32'h0, 5);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!out_valid && n < 20);
    chk("perf_first_valid", {31'h0, out_valid}, 32'h1);
    repeat (2) begin
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    out_ready = 1'b0;
    redirect(1'b0, 1'b1, 32'h0, 32'h300, 32'h0, 32'h300, "perf_br");
    redirect(1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 32'h400, "perf_jmp");
    @(negedge clk);
    chk("perf_fetch", perf_fetch_cnt, 32'd5);
    chk("perf_flush", perf_flush_cnt, 32'd2);
    chk("perf_stall", perf_stall_cnt, 32'd3);
    chk("perf_exp_left", exp_q.size(), 0);
    @(posedge clk); #2;
    do_reset();
    @(negedge clk);
    chk("perf_fetch_midrst", perf_fetch_cnt, 32'd0);
    chk("perf_flush_midrst", perf_flush_cnt, 32'd0);
    chk("perf_stall_midrst", perf_stall_cnt, 32'd0);
    chk("perf_midrst_pc", imem_req_addr, 32'h0);
`endif

    repeat (3) begin
      @(posedge clk); #2;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
